// File: rtl/cdc_hs_tx_pkg.sv
// Shared types and helpers for the O-domain toggle req/ack transmitter.
package cdc_hs_tx_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2
   } hsState_t;

   localparam int MIN_SYNC_STAGES = 2;

   // Bits needed to hold values 0..maxVal, never less than one.
   function automatic int bitsFor(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/cdc_hs_tx_sync.sv
// N-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module cdc_sync_n #(
   parameter int N = 2
) (
   input  logic i_Clk,
   input  logic i_aReset_N,
   input  logic i_aD,
   output logic o_Q
);

   logic [N-1:0] syncFf;

   always_ff @(posedge i_Clk or negedge i_aReset_N) begin
      if (!i_aReset_N) syncFf <= '0;
      else             syncFf <= {syncFf[N-2:0], i_aD};
   end

   assign o_Q = syncFf[N-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit end of a 2-phase toggle req/ack crossing out of the O domain:
// one word per handshake, held on o_xData until the far end echoes the toggle.
module cdc_hs_tx
   import cdc_hs_tx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  i_OClk,
   input  logic                  i_aOReset_N,
   input  logic [DATA_WIDTH-1:0] i_oData,
   input  logic                  i_oValid,
   output logic                  o_oReady,
   output logic [DATA_WIDTH-1:0] o_xData,
   output logic                  o_xReq,
   input  logic                  i_aAck,
   output logic                  o_oBusy,
   output logic                  o_oTimeout,
   input  logic                  i_oClrTimeout,
   output logic [CNT_WIDTH-1:0]  o_oTxCount
);

   localparam int FW = bitsFor(SYNC_STAGES);
   localparam int TW = bitsFor(TIMEOUT_CYCLES);

   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : gBadSync
      $error("cdc_hs_tx: SYNC_STAGES must be at least 2");
   end

   hsState_t      state, stateNxt;
   logic          ackS, ackMatch, flushed;
   logic [FW-1:0] flushCnt;
   logic [TW-1:0] toCnt;
   logic          toHit;
   logic          readyNxt, busyNxt, reqNxt, load, done;

   cdc_sync_n #(.N(SYNC_STAGES)) uAckSync (
      .i_Clk      (i_OClk),
      .i_aReset_N (i_aOReset_N),
      .i_aD       (i_aAck),
      .o_Q        (ackS)
   );

   assign ackMatch = (ackS == o_xReq);
   // The synchroniser resets to 0 whatever the far end holds, so its output is
   // only trusted once the reset zeros have been flushed through.
   assign flushed  = (flushCnt == FW'(SYNC_STAGES));

   always_comb begin
      stateNxt = state;
      readyNxt = o_oReady;
      busyNxt  = o_oBusy;
      reqNxt   = o_xReq;
      load     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_SYNC: begin
            readyNxt = 1'b0;
            if (flushed && ackMatch) begin
               stateNxt = ST_IDLE;
               readyNxt = 1'b1;
            end
         end
         ST_IDLE: begin
            if (!ackMatch) begin
               stateNxt = ST_SYNC;
               readyNxt = 1'b0;
            end else if (i_oValid) begin
               load     = 1'b1;
               reqNxt   = ~o_xReq;
               readyNxt = 1'b0;
               busyNxt  = 1'b1;
               stateNxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ackMatch) begin
               done     = 1'b1;
               busyNxt  = 1'b0;
               readyNxt = 1'b1;
               stateNxt = ST_IDLE;
            end
         end
         default: begin
            stateNxt = ST_SYNC;
            readyNxt = 1'b0;
            busyNxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
      if (!i_aOReset_N) begin
         state      <= ST_SYNC;
         o_oReady   <= 1'b0;
         o_oBusy    <= 1'b0;
         o_xReq     <= 1'b0;
         o_xData    <= '0;
         o_oTxCount <= '0;
         flushCnt   <= '0;
      end else begin
         state    <= stateNxt;
         o_oReady <= readyNxt;
         o_oBusy  <= busyNxt;
         o_xReq   <= reqNxt;
         if (load) o_xData <= i_oData;
         if (done) o_oTxCount <= o_oTxCount + CNT_WIDTH'(1);
         if (!flushed) flushCnt <= flushCnt + FW'(1);
      end
   end

   // Timeout only flags; aborting WAIT would desynchronise the toggle parity.
   assign toHit = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT) && !ackMatch &&
                  (toCnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
      if (!i_aOReset_N) begin
         toCnt      <= '0;
         o_oTimeout <= 1'b0;
      end else begin
         if (state != ST_WAIT || ackMatch)     toCnt <= '0;
         else if (toCnt != TW'(TIMEOUT_CYCLES)) toCnt <= toCnt + TW'(1);
         if (toHit)              o_oTimeout <= 1'b1;
         else if (i_oClrTimeout) o_oTimeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Random and directed stimulus for cdc_hs_tx, checked every cycle against a
// transaction-level reference model of the handshake rules.
module tb_cdc_hs_tx;

   localparam int DW = 8;
   localparam int SS = 2;
   localparam int TO = 16;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic [DW-1:0] iData = '0;
   logic          iValid = 1'b0;
   logic          aAck = 1'b0;
   logic          clrTo = 1'b0;
   logic          oReady, xReq, oBusy, oTimeout;
   logic [DW-1:0] xData;
   logic [CW-1:0] txCount;

   cdc_hs_tx #(
      .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
   ) dut (
      .i_OClk        (clk),
      .i_aOReset_N   (rstN),
      .i_oData       (iData),
      .i_oValid      (iValid),
      .o_oReady      (oReady),
      .o_xData       (xData),
      .o_xReq        (xReq),
      .i_aAck        (aAck),
      .o_oBusy       (oBusy),
      .o_oTimeout    (oTimeout),
      .i_oClrTimeout (clrTo),
      .o_oTxCount    (txCount)
   );

   always #5 clk = ~clk;

   int nVec = 0;
   int nErr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      if (obs !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: transfer-level view (idle/waiting/resyncing), ack seen
   // SS edges late, timeout after TO waiting edges, count modulo 2^CW.
   bit          mReady, mBusy, mReq, mTo, mAcc;
   logic [DW-1:0] mData;
   int          mTx, mWait, mK;
   bit          mAckQ[$];

   task automatic mdlReset();
      mReady = 0; mBusy = 0; mReq = 0; mTo = 0; mAcc = 0;
      mData = '0; mTx = 0; mWait = 0; mK = 0;
      mAckQ = {};
      for (int i = 0; i < SS; i++) mAckQ.push_back(1'b0);
   endtask

   task automatic mdlStep();
      bit ackS, set;
      set = 0;
      mK++;
      ackS = mAckQ.pop_front();
      mAckQ.push_back(aAck);
      if (mBusy) begin
         if (ackS == mReq) begin
            mBusy = 0; mReady = 1; mTx++;
         end else begin
            mWait++;
            set = (mWait == TO);
         end
      end else if (mReady) begin
         if (ackS != mReq) mReady = 0;
         else if (iValid) begin
            mData = iData; mReq = !mReq; mReady = 0; mBusy = 1; mWait = 0; mAcc = 1;
         end
      end else if (mK > SS && ackS == mReq) begin
         mReady = 1;
      end
      if (set) mTo = 1;
      else if (clrTo) mTo = 0;
   endtask

   task automatic compareAll();
      chk("ready",   oReady,   mReady);
      chk("busy",    oBusy,    mBusy);
      chk("req",     xReq,     mReq);
      chk("data",    xData,    mData);
      chk("timeout", oTimeout, mTo);
      chk("txcnt",   txCount,  mTx % (1 << CW));
   endtask

   // Far-end emulator: echoes the req toggle after ackDly cycles (random if <0).
   bit autoAck = 0;
   int ackDly = 5;
   int pend = -1;

   task automatic farEnd();
      if (autoAck && xReq != aAck) begin
         if (pend < 0) pend = (ackDly < 0) ? int'($urandom_range(1, 24)) : ackDly;
         if (pend == 0) begin
            aAck = xReq;
            pend = -1;
         end else pend--;
      end
   endtask

   task automatic tick();
      mAcc = 0;
      @(posedge clk);
      if (rstN) mdlStep();
      @(negedge clk);
      compareAll();
      farEnd();
   endtask

   task automatic sendWord(input logic [DW-1:0] d);
      bit got;
      got = 0;
      iData = d;
      iValid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         got = mAcc;
      end
      if (!got) chk("accept_bound", 32'd0, 32'd1);
   endtask

   task automatic waitIdle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = mReady && !mBusy;
      end
      if (!ok) chk("idle_bound", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit prevReq;
      logic [DW-1:0] bbData [3];
      mdlReset();
      repeat (2) @(negedge clk);
      compareAll();

      // Reset release: ready exactly SS+1 edges later.
      rstN = 1'b1;
      tick(); tick();
      chk("rdy_edge2", oReady, 1'b0);
      tick();
      chk("rdy_edge3", oReady, 1'b1);

      // Single word, far end acks 5 cycles after req.
      autoAck = 1; ackDly = 5;
      sendWord(8'hA5);
      iValid = 1'b0;
      waitIdle();
      chk("t2_cnt", txCount, 2'd1);
      chk("t2_data", xData, 8'hA5);

      // Back-to-back with valid held high; each accept only after the previous ack.
      bbData = '{8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 3; i++) begin
         sendWord(bbData[i]);
         chk("bb_data", xData, bbData[i]);
      end
      iValid = 1'b0;
      waitIdle();
      chk("t3_cnt", txCount, 2'd0);
      sendWord(8'h04);
      iValid = 1'b0;
      waitIdle();
      chk("wrap_cnt", txCount, 2'd1);

      // Timeout with no ack, clear, then late ack completes.
      autoAck = 0;
      sendWord(8'h5A);
      iValid = 1'b0;
      repeat (TO - 1) tick();
      chk("to_early", oTimeout, 1'b0);
      tick();
      chk("to_set", oTimeout, 1'b1);
      chk("to_busy", oBusy, 1'b1);
      repeat (5) tick();
      clrTo = 1'b1;
      tick();
      clrTo = 1'b0;
      chk("to_clr", oTimeout, 1'b0);
      repeat (8) tick();
      chk("to_noreset", oTimeout, 1'b0);
      aAck = xReq;
      waitIdle();
      chk("to_late_cnt", txCount, 2'd2);

      // Reset mid-WAIT while the far end still holds ack high.
      autoAck = 1; ackDly = 3;
      sendWord(8'h11);
      iValid = 1'b0;
      waitIdle();
      autoAck = 0;
      sendWord(8'h22);
      iValid = 1'b0;
      tick(); tick();
      rstN = 1'b0;
      aAck = 1'b1;
      mdlReset();
      #1;
      compareAll();
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (10) tick();
      chk("t5_hold", oReady, 1'b0);
      aAck = 1'b0;
      waitIdle();
      chk("t5_rdy", oReady, 1'b1);

      // Spurious ack toggle in IDLE, valid raised on the edge it is seen.
      prevReq = xReq;
      aAck = ~aAck;
      tick(); tick();
      iData = 8'h77;
      iValid = 1'b1;
      tick();
      chk("t6_rdy", oReady, 1'b0);
      chk("t6_busy", oBusy, 1'b0);
      chk("t6_req", xReq, prevReq);
      repeat (4) tick();
      iValid = 1'b0;
      aAck = xReq;
      waitIdle();
      chk("t6_recover", oReady, 1'b1);

      // Random traffic with random ack latency (some beyond the timeout).
      autoAck = 1; ackDly = -1; pend = -1;
      for (int c = 0; c < 3000; c++) begin
         iValid = 1'($urandom_range(0, 1));
         iData  = DW'($urandom);
         clrTo  = ($urandom_range(0, 39) == 0);
         tick();
      end
      iValid = 1'b0;
      clrTo = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
